rmst_tile_load_sched: RTL and testbench
=======================================

Name: rmst_tile_load_sched

Overview:
- Sequencer driving one read-master-to-RAM tile loader across a list of consecutive tiles in external memory.
- Computes each tile's base address, pulses the loader's config_done and load_data_start, then waits for load_data_done.
- Manages ping-pong ownership of two on-chip tile buffers against a downstream compute consumer, so loading tile k+1 overlaps computing tile k.

Parameters:
- XAW, 32, external byte-address width
- AW, 12, tile length width in 32-bit words
- NTW, 8, tile count width
- TO_W, 16, watchdog counter width (used only with TILE_TIMEOUT_EN)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begin a sequence (ignored unless idle)
- base_addr  in  XAW  byte address of tile 0
- tile_len  in  AW  words per tile, legal range 2..2^AW-1
- tile_stride  in  XAW  byte distance between tile bases
- tile_num  in  NTW  tiles to load, legal range 1..2^NTW-1
- config_done  out  1  one-cycle pulse to loader
- param_raddr  out  XAW  tile base to loader
- param_iolen  out  AW  tile length to loader
- load_data_start  out  1  one-cycle pulse to loader
- load_data_done  in  1  loader completion level
- wr_buf  out  1  buffer index currently being filled
- rd_buf  out  1  buffer index the consumer owns next
- buf_full  out  2  per-buffer valid flags
- buf_ready  out  1  one-cycle pulse when a tile lands; buffer index = previous wr_buf
- cons_release  in  1  one-cycle pulse; consumer frees rd_buf
- busy  out  1  high outside IDLE
- all_done  out  1  one-cycle pulse at sequence end
- err  out  1  sticky error, cleared only by the next accepted start

Behaviour:
- Reset values: all outputs 0; FSM = IDLE; tile_idx = 0; addr = 0.
- IDLE: on start:
  - if tile_num == 0 or tile_len < 2: set err, pulse all_done next cycle, stay idle.
  - otherwise latch base_addr, tile_len, tile_stride, tile_num; set addr = base_addr, tile_idx = 0, clear err; go to WAIT_BUF.
- WAIT_BUF: when buf_full[wr_buf] == 0, go to CFG; otherwise stall.
- CFG: config_done = 1 for exactly one cycle; param_raddr = addr and param_iolen = tile_len are registered and held stable until the next CFG. Go to START.
- START: load_data_start = 1 for exactly one cycle. Go to LOAD.
- LOAD:
  - Completion is a rising edge of load_data_done, using a 1-cycle registered copy.
  - A level already high on LOAD entry does not count.
  - On completion: buf_full[wr_buf] <= 1, buf_ready pulse, wr_buf toggles, addr <= addr + tile_stride (mod 2^XAW), tile_idx++.
  - If tile_idx was tile_num-1, go to DONE; otherwise go to WAIT_BUF.
- DONE: all_done pulse, then IDLE. rd_buf, wr_buf and buf_full are retained across sequences; only reset clears them.
- Consumer side:
  - cons_release with buf_full[rd_buf] == 1: clear it and toggle rd_buf.
  - cons_release with buf_full[rd_buf] == 0: ignored, sets err.
- Simultaneous completion and release in the same cycle: both updates apply. The index bits are independent, so both act correctly.
- start while busy: ignored; no err.
- Latency: start to first config_done is 2 cycles when the buffer is free. The inter-tile gap after completion is 3 cycles (WAIT_BUF, CFG, START) plus any buffer stall.
- Asynchronous reset mid-sequence returns everything to reset values immediately. The loader must be reset alongside.

Optional Feature:
- Macro TILE_TIMEOUT_EN.
- When defined:
  - a TO_W-bit watchdog clears on LOAD entry and increments each LOAD cycle.
  - on reaching all-ones before completion: set err, abort to DONE (all_done pulses), leave buf_full untouched and do not toggle wr_buf.
- When undefined: LOAD waits indefinitely and the watchdog logic is absent.

Test Plan:
- Basic: base=0x1000, stride=0x40, len=16, num=3; consumer releases each tile 5 cycles after buf_ready -> param_raddr 0x1000, 0x1040, 0x1080; three buf_ready pulses; wr_buf sequence 0,1,0; all_done once; err=0.
- Back-pressure: num=4, no releases -> after tiles 0,1 buf_full=2'b11, FSM held in WAIT_BUF with no config_done; one release -> third config_done within 2 cycles.
- Same-cycle events: cons_release coincides with the load_data_done rising edge -> both buf_full bits update correctly; no err.
- Illegal inputs: tile_num=0 -> err=1, all_done pulse, no config_done. Release with buf_full=0 -> err=1, rd_buf unchanged.
- Reset and busy start: rst_n low during LOAD of tile 1 -> all outputs 0 immediately; a fresh start completes normally. A start pulse while busy changes nothing.
- Watchdog (TILE_TIMEOUT_EN, TO_W=4): load_data_done never rises -> err=1 and all_done 16 cycles after LOAD entry; buf_full unchanged.

Source files
------------

// File: rtl/rmst_tile_load_sched.sv
`default_nettype none
// ============================================================================
// Module      : rmst_tile_load_sched
// Description : Sequences a read-master tile loader over consecutive tiles in
//               external memory. It hands each tile base and length to the
//               loader, then waits for the loader to finish. Two on-chip
//               buffers are used as a ping-pong pair with a downstream
//               consumer, so the next tile loads while the current one is
//               being computed.
// Options     : `define TILE_TIMEOUT_EN adds a LOAD watchdog of TO_W bits.
//               When the watchdog expires, err is set and the sequence aborts.
// Revision    : 1.0 - initial release
// ============================================================================
module rmst_tile_load_sched #(
  parameter int XAW  = 32,
  parameter int AW   = 12,
  parameter int NTW  = 8,
  parameter int TO_W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_start,
  input  logic [XAW-1:0] i_base_addr,
  input  logic [AW-1:0]  i_tile_len,
  input  logic [XAW-1:0] i_tile_stride,
  input  logic [NTW-1:0] i_tile_num,
  output logic           o_config_done,
  output logic [XAW-1:0] o_param_raddr,
  output logic [AW-1:0]  o_param_iolen,
  output logic           o_load_data_start,
  input  logic           i_load_data_done,
  output logic           o_wr_buf,
  output logic           o_rd_buf,
  output logic [1:0]     o_buf_full,
  output logic           o_buf_ready,
  input  logic           i_cons_release,
  output logic           o_busy,
  output logic           o_all_done,
  output logic           o_err
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_BUF = 3'd1,
    S_CFG      = 3'd2,
    S_START    = 3'd3,
    S_LOAD     = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t         r_state;
  state_t         w_state_nx;

  logic [XAW-1:0] r_addr;
  logic [XAW-1:0] r_stride;
  logic [AW-1:0]  r_len;
  logic [NTW-1:0] r_tile_num;
  logic [NTW-1:0] r_tile_idx;
  logic [XAW-1:0] r_param_raddr;
  logic [AW-1:0]  r_param_iolen;
  logic           r_wr_buf;
  logic           r_rd_buf;
  logic [1:0]     r_buf_full;
  logic           r_buf_ready;
  logic           r_err;
  logic           r_bad_start;
  logic           r_ldd_q;

  logic w_start_ok;
  logic w_accept;
  logic w_reject;
  logic w_buf_free;
  logic w_load_done;
  logic w_last;
  logic w_rel_ok;
  logic w_rel_bad;
  logic w_wdog_expire;

  assign w_start_ok  = (i_tile_num != '0) && (i_tile_len >= AW'(2));
  assign w_accept    = (r_state == S_IDLE) && i_start && w_start_ok;
  assign w_reject    = (r_state == S_IDLE) && i_start && !w_start_ok;
  assign w_buf_free  = !r_buf_full[r_wr_buf];
  // Only a fresh rising edge seen inside LOAD counts as completion, so a
  // level left high from the previous tile cannot complete the next one.
  assign w_load_done = (r_state == S_LOAD) && i_load_data_done && !r_ldd_q;
  assign w_last      = (r_tile_idx == (r_tile_num - NTW'(1)));
  assign w_rel_ok    = i_cons_release && r_buf_full[r_rd_buf];
  assign w_rel_bad   = i_cons_release && !r_buf_full[r_rd_buf];

`ifdef TILE_TIMEOUT_EN
  logic [TO_W-1:0] r_wdog;

  // Watchdog: cleared on the way into LOAD, advances on every LOAD cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog <= '0;
    end else if (r_state == S_START) begin
      r_wdog <= '0;
    end else if (r_state == S_LOAD) begin
      r_wdog <= r_wdog + TO_W'(1);
    end
  end

  // A completion in the same cycle as expiry wins over the abort.
  assign w_wdog_expire = (r_state == S_LOAD) && (&r_wdog) && !w_load_done;
`else
  assign w_wdog_expire = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  // Next-state logic for the tile sequence.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:     if (w_accept)   w_state_nx = S_WAIT_BUF;
      S_WAIT_BUF: if (w_buf_free) w_state_nx = S_CFG;
      S_CFG:      w_state_nx = S_START;
      S_START:    w_state_nx = S_LOAD;
      S_LOAD: begin
        if (w_load_done)        w_state_nx = w_last ? S_DONE : S_WAIT_BUF;
        else if (w_wdog_expire) w_state_nx = S_DONE;
      end
      S_DONE:     w_state_nx = S_IDLE;
      default:    w_state_nx = S_IDLE;
    endcase
  end

  // Sequence context: latched on accept, advanced per landed tile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= '0;
      r_stride   <= '0;
      r_len      <= '0;
      r_tile_num <= '0;
      r_tile_idx <= '0;
    end else if (w_accept) begin
      r_addr     <= i_base_addr;
      r_stride   <= i_tile_stride;
      r_len      <= i_tile_len;
      r_tile_num <= i_tile_num;
      r_tile_idx <= '0;
    end else if (w_load_done) begin
      r_addr     <= r_addr + r_stride;
      r_tile_idx <= r_tile_idx + NTW'(1);
    end
  end

  // Loader parameters: captured entering CFG, held until the next CFG.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_param_raddr <= '0;
      r_param_iolen <= '0;
    end else if ((r_state == S_WAIT_BUF) && w_buf_free) begin
      r_param_raddr <= r_addr;
      r_param_iolen <= r_len;
    end
  end

  // Ping-pong ownership. Fill and release always target different buffers
  // (a buffer is filled only when empty), so both updates may land together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_buf    <= 1'b0;
      r_rd_buf    <= 1'b0;
      r_buf_full  <= 2'b00;
      r_buf_ready <= 1'b0;
    end else begin
      r_buf_ready <= w_load_done;
      if (w_rel_ok) begin
        r_buf_full[r_rd_buf] <= 1'b0;
        r_rd_buf             <= ~r_rd_buf;
      end
      if (w_load_done) begin
        r_buf_full[r_wr_buf] <= 1'b1;
        r_wr_buf             <= ~r_wr_buf;
      end
    end
  end

  // Status: sticky error, illegal-start done pulse, done-level history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err       <= 1'b0;
      r_bad_start <= 1'b0;
      r_ldd_q     <= 1'b0;
    end else begin
      r_bad_start <= w_reject;
      r_ldd_q     <= i_load_data_done;
      if (w_reject || w_rel_bad || w_wdog_expire) r_err <= 1'b1;
      else if (w_accept)                          r_err <= 1'b0;
    end
  end

  assign o_config_done     = (r_state == S_CFG);
  assign o_load_data_start = (r_state == S_START);
  assign o_busy            = (r_state != S_IDLE);
  assign o_all_done        = (r_state == S_DONE) || r_bad_start;
  assign o_param_raddr     = r_param_raddr;
  assign o_param_iolen     = r_param_iolen;
  assign o_wr_buf          = r_wr_buf;
  assign o_rd_buf          = r_rd_buf;
  assign o_buf_full        = r_buf_full;
  assign o_buf_ready       = r_buf_ready;
  assign o_err             = r_err;

endmodule
`default_nettype wire

// File: tb/tb_rmst_tile_load_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_rmst_tile_load_sched
// Description : Randomized bench for rmst_tile_load_sched. It drives a
//               responsive loader and consumer, and compares every output on
//               every cycle against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rmst_tile_load_sched;

  localparam int XAW  = 32;
  localparam int AW   = 12;
  localparam int NTW  = 8;
  localparam int TO_W = 16;
  localparam int NCYC = 6000;

  localparam int PH_IDLE  = 0;
  localparam int PH_WAIT  = 1;
  localparam int PH_CFG   = 2;
  localparam int PH_START = 3;
  localparam int PH_LOAD  = 4;
  localparam int PH_DONE  = 5;

  logic           clk    = 1'b0;
  logic           rst_n  = 1'b0;
  logic           start  = 1'b0;
  logic [XAW-1:0] base   = '0;
  logic [AW-1:0]  len    = '0;
  logic [XAW-1:0] stride = '0;
  logic [NTW-1:0] num    = '0;
  logic           ldd    = 1'b0;
  logic           rel    = 1'b0;

  logic           o_config_done;
  logic [XAW-1:0] o_param_raddr;
  logic [AW-1:0]  o_param_iolen;
  logic           o_load_data_start;
  logic           o_wr_buf;
  logic           o_rd_buf;
  logic [1:0]     o_buf_full;
  logic           o_buf_ready;
  logic           o_busy;
  logic           o_all_done;
  logic           o_err;

  rmst_tile_load_sched #(
    .XAW (XAW),
    .AW  (AW),
    .NTW (NTW),
    .TO_W(TO_W)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_start          (start),
    .i_base_addr      (base),
    .i_tile_len       (len),
    .i_tile_stride    (stride),
    .i_tile_num       (num),
    .o_config_done    (o_config_done),
    .o_param_raddr    (o_param_raddr),
    .o_param_iolen    (o_param_iolen),
    .o_load_data_start(o_load_data_start),
    .i_load_data_done (ldd),
    .o_wr_buf         (o_wr_buf),
    .o_rd_buf         (o_rd_buf),
    .o_buf_full       (o_buf_full),
    .o_buf_ready      (o_buf_ready),
    .i_cons_release   (rel),
    .o_busy           (o_busy),
    .o_all_done       (o_all_done),
    .o_err            (o_err)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model state.
  int             m_ph;
  int             m_left;
  logic [XAW-1:0] q_addr[$];
  logic [AW-1:0]  m_len;
  logic [XAW-1:0] m_raddr;
  logic [AW-1:0]  m_iolen;
  logic [1:0]     m_full;
  logic           m_wr, m_rd, m_err, m_ldd_q;
  logic           m_cfg, m_lds, m_rdy, m_all;

  // Loader stimulus state.
  int ld_cnt = 0;
  bit did_reset = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph = PH_IDLE; m_left = 0; q_addr.delete();
    m_len = '0; m_raddr = '0; m_iolen = '0; m_full = 2'b00;
    m_wr = 1'b0; m_rd = 1'b0; m_err = 1'b0; m_ldd_q = 1'b0;
    m_cfg = 1'b0; m_lds = 1'b0; m_rdy = 1'b0; m_all = 1'b0;
  endtask

  // One clock edge of the reference: consumes the inputs presented this cycle.
  task automatic model_step();
    logic [1:0] full0;
    full0 = m_full;
    m_cfg = 1'b0; m_lds = 1'b0; m_rdy = 1'b0; m_all = 1'b0;
    case (m_ph)
      PH_IDLE: if (start) begin
        if (num == 0 || len < 2) begin
          m_err = 1'b1; m_all = 1'b1;
        end else begin
          q_addr.delete();
          for (int k = 0; k < int'(num); k++) q_addr.push_back(base + stride * 32'(k));
          m_len = len; m_left = int'(num); m_err = 1'b0; m_ph = PH_WAIT;
        end
      end
      PH_WAIT: if (!full0[m_wr] && q_addr.size() > 0) begin
        m_raddr = q_addr.pop_front(); m_iolen = m_len; m_cfg = 1'b1; m_ph = PH_CFG;
      end
      PH_CFG:   begin m_lds = 1'b1; m_ph = PH_START; end
      PH_START: m_ph = PH_LOAD;
      PH_LOAD: if (ldd && !m_ldd_q) begin
        m_full[m_wr] = 1'b1; m_wr = ~m_wr; m_rdy = 1'b1; m_left--;
        if (m_left == 0) begin m_all = 1'b1; m_ph = PH_DONE; end
        else m_ph = PH_WAIT;
      end
      PH_DONE:  m_ph = PH_IDLE;
      default:  m_ph = PH_IDLE;
    endcase
    if (rel) begin
      if (full0[m_rd]) begin m_full[m_rd] = 1'b0; m_rd = ~m_rd; end
      else m_err = 1'b1;
    end
    m_ldd_q = ldd;
  endtask

  task automatic compare_outputs();
    check("busy",            o_busy,            m_ph != PH_IDLE);
    check("config_done",     o_config_done,     m_cfg);
    check("param_raddr",     o_param_raddr,     m_raddr);
    check("param_iolen",     o_param_iolen,     m_iolen);
    check("load_data_start", o_load_data_start, m_lds);
    check("wr_buf",          o_wr_buf,          m_wr);
    check("rd_buf",          o_rd_buf,          m_rd);
    check("buf_full",        o_buf_full,        m_full);
    check("buf_ready",       o_buf_ready,       m_rdy);
    check("all_done",        o_all_done,        m_all);
    check("err",             o_err,             m_err);
  endtask

  // Drives the next cycle's inputs: loader response, consumer, new starts.
  task automatic drive(input int c);
    bit rising;
    rising = 1'b0;
    if (o_load_data_start) begin
      ldd = 1'b0; ld_cnt = $urandom_range(1, 6);
    end else if (ld_cnt > 0) begin
      ld_cnt--;
      if (ld_cnt == 0) begin ldd = 1'b1; rising = 1'b1; end
    end

    rel = 1'b0;
    if (m_full[m_rd] && (($urandom % 4) == 0 || (rising && ($urandom % 2) == 0))) rel = 1'b1;
    else if (($urandom % 80) == 0) rel = 1'b1;

    start = 1'b0;
    if (c == 3) begin
      start = 1'b1; base = 32'h1000; stride = 32'h40; len = 12'd16; num = 8'd3;
    end else if (c > 3 && ($urandom % 25) == 0) begin
      start  = 1'b1;
      base   = $urandom;
      stride = (($urandom % 4) == 0) ? $urandom : 32'h40 * 32'($urandom_range(1, 8));
      len    = (($urandom % 10) == 0) ? 12'($urandom_range(0, 1)) : 12'($urandom_range(2, 4095));
      num    = (($urandom % 10) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
    end

    if (!did_reset && c > 3000 && m_ph == PH_LOAD) begin
      did_reset = 1;
      rst_n = 1'b0;
      #1;
      model_reset();
      compare_outputs();
      ldd = 1'b0; ld_cnt = 0; rel = 1'b0; start = 1'b0;
      @(negedge clk);
      compare_outputs();
      rst_n = 1'b1;
    end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    compare_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_outputs();
      drive(c);
    end
    if (!did_reset) check("mid_load_reset_reached", 1'b0, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
